point_add_scheduler: RTL and testbench

- Shares one `point_add` datapath between N_REQ requesters, e.g. MSM bucket accumulators.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the adder's active-high `Reset`/`Done` protocol, captures R, and returns it to the winner over a valid/ready response channel.
- Adds a watchdog so a hung adder cannot stall the system.

---
 rtl/point_add_scheduler.sv | 168 ++++++++++++++++
 tb/tb_point_add_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/point_add_scheduler.sv
// point_add_scheduler: shares one point_add datapath between N_REQ requesters.
// Round-robin grant, operand latch, adder Reset/Done sequencing, watchdog abort,
// and a one-hot valid/ready response channel back to the winner.
module point_add_scheduler #(
  parameter int  N_REQ   = 4,
  parameter int  RST_CYC = 2,
  parameter int  TIMEOUT = 4096,
  parameter int  IDW     = $clog2(N_REQ),
  parameter type curve_point_t = logic [31:0]
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  curve_point_t         req_P [N_REQ],
  input  curve_point_t         req_Q [N_REQ],
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output curve_point_t         rsp_R,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 pa_Reset,
  output curve_point_t         pa_P,
  output curve_point_t         pa_Q,
  input  logic                 pa_Done,
  input  curve_point_t         pa_R
);

  localparam int CNT_MAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  curve_point_t       pa_p_q, pa_p_d;
  curve_point_t       pa_q_q, pa_q_d;
  curve_point_t       rsp_r_q, rsp_r_d;
  logic               rsp_err_q, rsp_err_d;

  logic [2*N_REQ-1:0] req_rot;
  logic [IDW-1:0]     win_off;
  logic [IDW:0]       win_sum;
  logic [IDW-1:0]     win_idx;
  logic               win_found;

  // Round-robin search: rotate a doubled request vector by rr_ptr so the first
  // set bit gives the offset from rr_ptr; the offset is then wrapped modulo N_REQ.
  always_comb begin
    req_rot   = {req_valid, req_valid} >> rr_ptr_q;
    win_found = 1'b0;
    win_off   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_off   = IDW'(i);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= (IDW+1)'(N_REQ)) begin
      win_sum = win_sum - (IDW+1)'(N_REQ);
    end
    win_idx = win_sum[IDW-1:0];
  end

  // Handshake-facing outputs decoded from the state register.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == S_IDLE && win_found && Reset) begin
      req_ready[win_idx] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rsp_valid[grant_id_q] = 1'b1;
    end
    pa_Reset = (state_q == S_IDLE) || (state_q == S_LOAD);
    busy     = (state_q != S_IDLE);
  end

  // Next-state and datapath updates for the IDLE/LOAD/RUN/RESP sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    pa_p_d     = pa_p_q;
    pa_q_d     = pa_q_q;
    rsp_r_d    = rsp_r_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          pa_p_d     = req_P[win_idx];
          pa_q_d     = req_Q[win_idx];
          grant_id_d = win_idx;
          cnt_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Done is tested first so it wins over a coincident timeout.
        if (pa_Done) begin
          rsp_r_d   = pa_R;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_r_d   = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[grant_id_q]) begin
          rr_ptr_d = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      pa_p_q     <= '0;
      pa_q_q     <= '0;
      rsp_r_q    <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      pa_p_q     <= pa_p_d;
      pa_q_q     <= pa_q_d;
      rsp_r_q    <= rsp_r_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign grant_id = grant_id_q;
  assign pa_P     = pa_p_q;
  assign pa_Q     = pa_q_q;
  assign rsp_R    = rsp_r_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_point_add_scheduler.sv
// Testbench for point_add_scheduler: model adder plus a reference model that
// predicts winner, latency, result and error from the arbitration rules.
module tb_point_add_scheduler;

  localparam int N  = 4;
  localparam int RC = 2;
  localparam int TO = 16;

  typedef logic [31:0] pt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  pt_t          req_P [N];
  pt_t          req_Q [N];
  pt_t          rsp_R, pa_P, pa_Q, pa_R;
  logic         rsp_err, busy, pa_Reset, pa_Done;
  logic [1:0]   grant_id;

  int done_at = 0;   // RUN cycle (1-based) in which the model adder raises Done; 0 = never
  int run_cyc;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr = 0;   // reference round-robin pointer

  point_add_scheduler #(
    .N_REQ(N),
    .RST_CYC(RC),
    .TIMEOUT(TO),
    .curve_point_t(pt_t)
  ) dut (
    .clk(clk),
    .Reset(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_P(req_P),
    .req_Q(req_Q),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_R(rsp_R),
    .rsp_err(rsp_err),
    .busy(busy),
    .grant_id(grant_id),
    .pa_Reset(pa_Reset),
    .pa_P(pa_P),
    .pa_Q(pa_Q),
    .pa_Done(pa_Done),
    .pa_R(pa_R)
  );

  always #5 clk = ~clk;

  // Model adder: counts cycles since its Reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        run_cyc <= 0;
    else if (pa_Reset) run_cyc <= 0;
    else               run_cyc <= run_cyc + 1;
  end
  assign pa_Done = !pa_Reset && (done_at > 0) && (run_cyc == done_at - 1);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      req_P[i] = $urandom;
      req_Q[i] = $urandom;
    end
  endtask

  // One full operation; entered and left at a falling edge with the DUT in IDLE.
  task automatic run_op(input logic [N-1:0] mask, input int k, input pt_t r,
                        input int stall, input bit fix, input pt_t pf, input pt_t qf);
    int  win;
    int  lat;
    int  exp_lat;
    bit  exp_err;
    pt_t exp_r, ep, eq;
    for (int i = 0; i < N; i++) begin
      req_P[i] = fix ? pf : pt_t'($urandom);
      req_Q[i] = fix ? qf : pt_t'($urandom);
    end
    req_valid = mask;
    rsp_ready = '0;
    done_at   = k;
    pa_R      = r;
    win = -1;
    for (int s = 0; s < N; s++) begin
      if (win < 0 && mask[(exp_ptr + s) % N]) win = (exp_ptr + s) % N;
    end
    ep      = req_P[win];
    eq      = req_Q[win];
    exp_err = (k == 0) || (k > TO);
    exp_lat = 1 + RC + (exp_err ? TO : k);
    exp_r   = exp_err ? '0 : r;
    #1;
    check_eq("idle_req_ready", req_ready, 64'(1 << win));
    check_eq("idle_busy", busy, 0);
    check_eq("idle_pa_reset", pa_Reset, 1);
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      scramble();
      #1;
      if (rsp_valid != '0 || lat > 200) break;
      check_eq("op_pa_reset", pa_Reset, (lat <= RC) ? 1 : 0);
      check_eq("op_busy", busy, 1);
      check_eq("op_req_ready", req_ready, 0);
      check_eq("op_pa_P", pa_P, ep);
      check_eq("op_pa_Q", pa_Q, eq);
    end
    check_eq("latency", lat, exp_lat);
    check_eq("rsp_valid", rsp_valid, 64'(1 << win));
    check_eq("grant_id", grant_id, win);
    check_eq("rsp_R", rsp_R, exp_r);
    check_eq("rsp_err", rsp_err, exp_err);
    rsp_ready = (stall > 0) ? ~(N'(1) << win) : '1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      scramble();
      #1;
      check_eq("stall_rsp_valid", rsp_valid, 64'(1 << win));
      check_eq("stall_rsp_R", rsp_R, exp_r);
      check_eq("stall_rsp_err", rsp_err, exp_err);
      check_eq("stall_pa_P", pa_P, ep);
      check_eq("stall_pa_Q", pa_Q, eq);
      check_eq("stall_req_ready", req_ready, 0);
      if (s == stall - 1) rsp_ready = '1;
    end
    @(posedge clk);
    exp_ptr = (win + 1) % N;
    @(negedge clk);
    #1;
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_busy", busy, 0);
  endtask

  initial begin
    req_valid = '1;
    rsp_ready = '0;
    pa_R      = '0;
    for (int i = 0; i < N; i++) begin
      req_P[i] = '0;
      req_Q[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_pa_reset", pa_Reset, 1);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_R", rsp_R, 0);
    check_eq("rst_pa_P", pa_P, 0);
    check_eq("rst_pa_Q", pa_Q, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;

    // Round-robin with every requester asserting and no backpressure.
    for (int i = 0; i < 8; i++) begin
      run_op('1, int'($urandom_range(1, 12)), pt_t'($urandom), 0, 1'b0, '0, '0);
      check_eq("rr_order", grant_id, i % N);
    end

    // Single op on requester 2, Done in the 10th RUN cycle.
    run_op(4'b0100, 10, {16'h00AA, 16'h00BB}, 0, 1'b1, {16'h0005, 16'h0007}, {16'h0003, 16'h0002});
    // inf_point fast path: Done in the first RUN cycle.
    run_op(N'($urandom_range(1, 15)), 1, {16'h0009, 16'h0004}, 0, 1'b0, '0, '0);
    // Response backpressure on requester 1.
    run_op(4'b0010, 5, pt_t'($urandom), 20, 1'b0, '0, '0);
    // Watchdog: never done, done on the timeout cycle, one past, then normal.
    run_op(N'($urandom_range(1, 15)), 0,  pt_t'($urandom), 2, 1'b0, '0, '0);
    run_op(N'($urandom_range(1, 15)), TO, pt_t'($urandom), 0, 1'b0, '0, '0);
    run_op(N'($urandom_range(1, 15)), TO + 1, pt_t'($urandom), 0, 1'b0, '0, '0);
    run_op(N'($urandom_range(1, 15)), 4,  pt_t'($urandom), 0, 1'b0, '0, '0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_op(N'($urandom_range(1, 15)), int'($urandom_range(0, 20)), pt_t'($urandom),
             int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    // Asynchronous reset in the middle of RUN.
    req_valid = 4'b1000;
    done_at   = 0;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #1;
    check_eq("pre_abort_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_pa_reset", pa_Reset, 1);
    check_eq("abort_rsp_valid", rsp_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_req_ready", req_ready, 0);
    check_eq("abort_grant_id", grant_id, 0);
    check_eq("abort_pa_P", pa_P, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ptr = 0;
    run_op('1, 3, pt_t'($urandom), 0, 1'b0, '0, '0);
    check_eq("post_abort_grant", grant_id, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
